// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit packed BCD converter (shift-and-add-3).
// One iteration per clock under a start/done handshake. The registered result saturates to 9999.
module bin_to_bcd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [13:0] bin_in,
    output logic [15:0] bcd_out,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] shift_q, shift_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ovf_cap_q, ovf_cap_d;
    logic [15:0] bcd_out_q, bcd_out_d;
    logic        overflow_q, overflow_d;
    logic        done_q, done_d;

    logic [15:0] adj;
    logic [29:0] shifted;

    // Add 3 to every BCD digit that is 5 or more before the shift.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nibble
            assign adj[gi*4 +: 4] = (shift_q[14 + gi*4 +: 4] >= 4'd5)
                                  ? shift_q[14 + gi*4 +: 4] + 4'd3
                                  : shift_q[14 + gi*4 +: 4];
        end
    endgenerate

    assign shifted = {adj[14:0], shift_q[13:0], 1'b0};

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        ovf_cap_d  = ovf_cap_q;
        bcd_out_d  = bcd_out_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = {16'h0000, bin_in};
                    cnt_d     = 4'd0;
                    ovf_cap_d = (bin_in > 14'd9999);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = shifted;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    // A carry out of the thousands digit can only come from an out-of-range value.
                    bcd_out_d  = (ovf_cap_q || adj[15]) ? 16'h9999 : shifted[29:14];
                    overflow_d = ovf_cap_q;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            ovf_cap_q  <= 1'b0;
            bcd_out_q  <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            ovf_cap_q  <= ovf_cap_d;
            bcd_out_q  <= bcd_out_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign bcd_out  = bcd_out_q;
    assign overflow = overflow_q;
    assign done     = done_q;
    assign busy     = (state_q == SHIFT);

endmodule
